jk_counter_reg: RTL and testbench
=================================

Name: jk_counter_reg

Overview:
- Parametrised successor to the single-bit JK flip-flop.
- A WIDTH-bit register that supports four modes: per-bit JK control (hold/reset/set/toggle), modulo up-count, modulo down-count, and parallel load.
- Wrap and saturate handling, with a terminal-count flag and a sticky overflow flag.
- Used as the general-purpose state/counter element in the sequential datapaths.

Parameters:
- WIDTH, 8: register width in bits.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1. Legal values are 2..2**WIDTH; anything else is a compile-time error.
- SATURATE, 0: 0 means up/down counts wrap; 1 means they stick at the range limit.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- clr, input, 1: reset, synchronous, active-high.
- en, input, 1: operation enable.
- mode, input, 2: 00 JK, 01 UP, 10 DOWN, 11 LOAD.
- J, input, WIDTH: per-bit J (used in JK mode).
- K, input, WIDTH: per-bit K (used in JK mode).
- d, input, WIDTH: parallel load data.
- ovf_clr, input, 1: clears the sticky ovf flag.
- Q, output, WIDTH: register value.
- Q_n, output, WIDTH: ~Q, combinational.
- tc, output, 1: terminal count, combinational.
- wrap, output, 1: registered one-cycle pulse on a range-limit event.
- ovf, output, 1: sticky overflow/range flag.

Behaviour:
- Reset:
  - Only clr is a reset, and it is sampled on the rising clk edge only.
  - clr=1 at an edge gives Q=0, wrap=0, ovf=0. This overrides en, mode and ovf_clr.
  - clr asserted mid-count takes effect at the next edge; the partial operation is discarded.
  - Reset values: Q=0, Q_n=all ones, wrap=0, ovf=0. tc follows its equation, so tc=1 if en=1 and mode=DOWN while in reset.
- en=0: Q holds, wrap=0 next cycle, ovf holds (subject to ovf_clr).
- JK mode, per bit i, with next value R:
  - {J,K}=00: R[i]=Q[i].
  - {J,K}=01: R[i]=0.
  - {J,K}=10: R[i]=1.
  - {J,K}=11: R[i]=~Q[i].
  - If R < MODULUS, Q=R.
  - Otherwise Q=MODULUS-1 and ovf is set; wrap is not pulsed.
- UP mode:
  - Q < MODULUS-1: Q=Q+1.
  - Q >= MODULUS-1: Q=(SATURATE ? MODULUS-1 : 0), wrap=1 next cycle, ovf set.
- DOWN mode:
  - Q > 0: Q=Q-1.
  - Q == 0: Q=(SATURATE ? 0 : MODULUS-1), wrap=1 next cycle, ovf set.
- LOAD mode:
  - d < MODULUS: Q=d.
  - Otherwise Q=MODULUS-1 and ovf is set.
- Arithmetic:
  - Internal compare/increment is done at WIDTH+1 bits, so there is no silent wrap when MODULUS = 2**WIDTH.
  - Q never leaves 0..MODULUS-1 after a JK, UP, DOWN or LOAD operation.
- tc = en & ((mode==UP & Q==MODULUS-1) | (mode==DOWN & Q==0)). It is zero-latency and precedes wrap by one cycle.
- wrap is registered. It is 1 for exactly one cycle after each UP/DOWN limit event; back-to-back limit events give back-to-back pulses (SATURATE=1 holding at the limit pulses every cycle).
- ovf:
  - Set by any limit or clip event.
  - Cleared by ovf_clr=1 at an edge, unless a set event occurs in the same cycle (set wins).
  - Holds otherwise.
- Latency: Q updates one edge after the inputs are sampled. No internal pipeline; throughput of one operation per cycle.
- No X propagation: undefined mode encodings cannot occur, since all 4 are defined.

Decomposition:
- Package jk_pkg:
  - typedef enum logic [1:0] jk_mode_t with MODE_JK, MODE_UP, MODE_DOWN, MODE_LOAD.
  - Function jk_next(q, j, k) returning a logic vector with the per-bit JK table.
- Sub-module jk_next_vec (combinational, WIDTH-parametrised): computes R from Q, J, K. It is reused elsewhere for plain JK register banks.
- Top jk_counter_reg holds the state, mode mux, range/limit logic and flags.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset: clr=1 with Q=7, mode=LOAD, d=3 → next edge Q=0, Q_n=4'hF, wrap=0, ovf=0. clr=1 with ovf_clr=0 still clears ovf.
- JK table: Q=4'b1010, J=4'b0101, K=4'b0011 → Q=4'b1001 (Q=9). Then J=K=4'b0110 toggles bits 1 and 2 → R=4'b1111 ≥ 10, so Q=9 and ovf=1.
- UP wrap, SATURATE=0: LOAD 8, then UP ×3 → Q=9 (tc=1), then 0 with wrap=1 for one cycle and ovf=1, then 1 with wrap=0.
- DOWN saturate, SATURATE=1: LOAD 1, DOWN ×3 → Q=0, 0, 0. tc=1 while Q=0; wrap pulses on the 2nd and 3rd edges.
- LOAD clip and ovf priority: LOAD d=12 → Q=9, ovf=1. ovf_clr=1 together with UP at Q=9 → ovf stays 1. ovf_clr=1 alone → ovf=0.
- Enable / default width: en=0 for 5 cycles with mode=UP, Q=4 → Q stays 4, tc=0, wrap=0. With WIDTH=8 and the default MODULUS, UP from 255 → 0 with wrap=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and JK next-state helpers for the JK counter register family.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } jk_mode_t;

    // Widest vector jk_next accepts; narrower callers zero-extend.
    localparam int JK_MAX_W = 64;

    function automatic logic jk_bit(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    function automatic logic [JK_MAX_W-1:0] jk_next(
        input logic [JK_MAX_W-1:0] q,
        input logic [JK_MAX_W-1:0] j,
        input logic [JK_MAX_W-1:0] k
    );
        logic [JK_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < JK_MAX_W; i++) begin
            r[i] = jk_bit(q[i], j[i], k[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_next_vec.sv
// Combinational per-bit JK next-value vector; also used by plain JK register banks.
module jk_next_vec
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] r
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign r[gi] = jk_bit(q[gi], j[gi], k[gi]);
        end
    endgenerate

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit JK / up / down / load register with modulo range, terminal count,
// one-cycle wrap pulse and sticky overflow flag.
module jk_counter_reg
    import jk_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] d,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
            $error("jk_counter_reg: WIDTH must be 1..30");
        end
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("jk_counter_reg: MODULUS must be 2..2**WIDTH");
        end
    endgenerate

    // Range compares run one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W     = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   LIMIT_W   = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] UP_AFTER  = (SATURATE != 0) ? Q_MAX : '0;
    localparam logic [WIDTH-1:0] DN_AFTER  = (SATURATE != 0) ? '0 : Q_MAX;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             ovf_reg;
    logic             limit_evt;
    logic             clip_evt;
    logic [WIDTH-1:0] r_vec;
    jk_mode_t         mode_sel;

    assign mode_sel = jk_mode_t'(mode);

    jk_next_vec #(
        .WIDTH(WIDTH)
    ) u_jk_next (
        .q(q_reg),
        .j(J),
        .k(K),
        .r(r_vec)
    );

    always_comb begin
        q_next    = q_reg;
        limit_evt = 1'b0;
        clip_evt  = 1'b0;
        if (en) begin
            case (mode_sel)
                MODE_JK: begin
                    if ({1'b0, r_vec} < MOD_W) begin
                        q_next = r_vec;
                    end else begin
                        q_next   = Q_MAX;
                        clip_evt = 1'b1;
                    end
                end
                MODE_UP: begin
                    if ({1'b0, q_reg} < LIMIT_W) begin
                        q_next = q_reg + WIDTH'(1);
                    end else begin
                        q_next    = UP_AFTER;
                        limit_evt = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (q_reg != '0) begin
                        q_next = q_reg - WIDTH'(1);
                    end else begin
                        q_next    = DN_AFTER;
                        limit_evt = 1'b1;
                    end
                end
                default: begin
                    if ({1'b0, d} < MOD_W) begin
                        q_next = d;
                    end else begin
                        q_next   = Q_MAX;
                        clip_evt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= limit_evt;
            // A set event in the same cycle beats ovf_clr.
            if (limit_evt || clip_evt) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign Q    = q_reg;
    assign Q_n  = ~q_reg;
    assign wrap = wrap_reg;
    assign ovf  = ovf_reg;
    assign tc   = en & (((mode_sel == MODE_UP) & (q_reg == Q_MAX)) |
                        ((mode_sel == MODE_DOWN) & (q_reg == '0)));

endmodule

// File: tb/tb_jk_counter_reg.sv
// Drives three jk_counter_reg configurations with shared stimulus and checks them
// against an integer reference model.
module tb_jk_counter_reg;

    logic       clk = 1'b0;
    logic       clr_s = 1'b1;
    logic       en_s = 1'b0;
    logic [1:0] mode_s = 2'b00;
    logic [7:0] j_s = '0;
    logic [7:0] k_s = '0;
    logic [7:0] d_s = '0;
    logic       oc_s = 1'b0;

    logic [3:0] q0, qn0, q1, qn1;
    logic [7:0] q2, qn2;
    logic       tc0, tc1, tc2, w0, w1, w2, o0, o1, o2;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Per-config parameters: 0 = wrapping mod-10, 1 = saturating mod-10, 2 = default 8-bit.
    int cw[3] = '{4, 4, 8};
    int cm[3] = '{10, 10, 256};
    int cs[3] = '{0, 1, 0};
    int mq[3] = '{0, 0, 0};
    int mw[3] = '{0, 0, 0};
    int mo[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clk(clk), .clr(clr_s), .en(en_s), .mode(mode_s),
        .J(j_s[3:0]), .K(k_s[3:0]), .d(d_s[3:0]), .ovf_clr(oc_s),
        .Q(q0), .Q_n(qn0), .tc(tc0), .wrap(w0), .ovf(o0)
    );

    jk_counter_reg #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .clk(clk), .clr(clr_s), .en(en_s), .mode(mode_s),
        .J(j_s[3:0]), .K(k_s[3:0]), .d(d_s[3:0]), .ovf_clr(oc_s),
        .Q(q1), .Q_n(qn1), .tc(tc1), .wrap(w1), .ovf(o1)
    );

    jk_counter_reg #(.WIDTH(8)) u_def (
        .clk(clk), .clr(clr_s), .en(en_s), .mode(mode_s),
        .J(j_s), .K(k_s), .d(d_s), .ovf_clr(oc_s),
        .Q(q2), .Q_n(qn2), .tc(tc2), .wrap(w2), .ovf(o2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int get_q(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            default: return int'(q2);
        endcase
    endfunction

    function automatic int get_qn(input int i);
        case (i)
            0:       return int'(qn0);
            1:       return int'(qn1);
            default: return int'(qn2);
        endcase
    endfunction

    function automatic int get_tc(input int i);
        case (i)
            0:       return int'(tc0);
            1:       return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int get_wrap(input int i);
        case (i)
            0:       return int'(w0);
            1:       return int'(w1);
            default: return int'(w2);
        endcase
    endfunction

    function automatic int get_ovf(input int i);
        case (i)
            0:       return int'(o0);
            1:       return int'(o1);
            default: return int'(o2);
        endcase
    endfunction

    function automatic int model_tc(input int i);
        if (!en_s) return 0;
        if (mode_s == 2'd1 && mq[i] == cm[i] - 1) return 1;
        if (mode_s == 2'd2 && mq[i] == 0) return 1;
        return 0;
    endfunction

    // Behavioural next state: JK via its characteristic equation, counts as integer arithmetic.
    task automatic model_step(input int i);
        int mask, q, r, nq, setf, lim;
        mask = (1 << cw[i]) - 1;
        q = mq[i];
        nq = q;
        setf = 0;
        lim = 0;
        if (clr_s) begin
            mq[i] = 0;
            mw[i] = 0;
            mo[i] = 0;
        end else begin
            if (en_s) begin
                case (mode_s)
                    2'd0: begin
                        r = ((int'(j_s) & ~q) | (~int'(k_s) & q)) & mask;
                        if (r < cm[i]) nq = r;
                        else begin nq = cm[i] - 1; setf = 1; end
                    end
                    2'd1: begin
                        if (q + 1 < cm[i]) nq = q + 1;
                        else begin nq = cs[i] ? cm[i] - 1 : 0; lim = 1; end
                    end
                    2'd2: begin
                        if (q > 0) nq = q - 1;
                        else begin nq = cs[i] ? 0 : cm[i] - 1; lim = 1; end
                    end
                    default: begin
                        r = int'(d_s) & mask;
                        if (r < cm[i]) nq = r;
                        else begin nq = cm[i] - 1; setf = 1; end
                    end
                endcase
            end
            mq[i] = nq;
            mw[i] = lim;
            if (lim || setf) mo[i] = 1;
            else if (oc_s) mo[i] = 0;
        end
    endtask

    task automatic drv(input logic c, input logic e, input logic [1:0] m,
                       input logic [7:0] j, input logic [7:0] k,
                       input logic [7:0] dd, input logic oc);
        clr_s = c;
        en_s = e;
        mode_s = m;
        j_s = j;
        k_s = k;
        d_s = dd;
        oc_s = oc;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tc%0d", i), get_tc(i), model_tc(i));
        end
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("q%0d", i), get_q(i), mq[i]);
            chk($sformatf("qn%0d", i), get_qn(i), (~mq[i]) & ((1 << cw[i]) - 1));
            chk($sformatf("wrap%0d", i), get_wrap(i), mw[i]);
            chk($sformatf("ovf%0d", i), get_ovf(i), mo[i]);
        end
        $display("cyc=%0d clr=%0d en=%0d mode=%0d oc=%0d q=%0d/%0d/%0d wrap=%0d%0d%0d ovf=%0d%0d%0d",
                 cyc, clr_s, en_s, mode_s, oc_s, q0, q1, q2, w0, w1, w2, o0, o1, o2);
    endtask

    localparam logic [1:0] JK = 2'd0, UP = 2'd1, DN = 2'd2, LD = 2'd3;

    initial begin
        // Reset, and clr overriding a pending load with ovf set
        drv(1, 0, JK, 0, 0, 0, 0); cycle();
        chk("rst_q0", get_q(0), 0);
        chk("rst_qn0", get_qn(0), 15);
        drv(0, 1, LD, 0, 0, 12, 0); cycle();
        chk("clip_q0", get_q(0), 9);
        chk("clip_ovf0", get_ovf(0), 1);
        drv(0, 1, LD, 0, 0, 7, 0); cycle();
        drv(1, 1, LD, 0, 0, 3, 0); cycle();
        chk("clr_q0", get_q(0), 0);
        chk("clr_ovf0", get_ovf(0), 0);
        chk("clr_wrap0", get_wrap(0), 0);

        // JK table
        drv(0, 1, LD, 0, 0, 8'b1010, 0); cycle();
        drv(0, 1, JK, 8'b0101, 8'b0011, 0, 0); cycle();
        chk("jk1_q2", get_q(2), 13);
        drv(0, 1, JK, 8'b0110, 8'b0110, 0, 0); cycle();
        chk("jk2_q2", get_q(2), 11);
        chk("jk2_q0", get_q(0), 9);
        chk("jk2_ovf0", get_ovf(0), 1);

        // UP limit: wrap vs saturate
        drv(1, 0, JK, 0, 0, 0, 0); cycle();
        drv(0, 1, LD, 0, 0, 8, 0); cycle();
        drv(0, 1, UP, 0, 0, 0, 0); cycle();
        chk("up_q0_9", get_q(0), 9);
        chk("up_tc0", get_tc(0), 1);
        cycle();
        chk("up_q0_wrap", get_q(0), 0);
        chk("up_w0_1", get_wrap(0), 1);
        chk("up_ovf0", get_ovf(0), 1);
        chk("up_q1_sat", get_q(1), 9);
        cycle();
        chk("up_q0_1", get_q(0), 1);
        chk("up_w0_0", get_wrap(0), 0);
        chk("up_w1_again", get_wrap(1), 1);

        // DOWN limit with saturation
        drv(1, 0, JK, 0, 0, 0, 0); cycle();
        drv(0, 1, LD, 0, 0, 1, 0); cycle();
        drv(0, 1, DN, 0, 0, 0, 0); cycle();
        chk("dn_q1_a", get_q(1), 0);
        chk("dn_w1_a", get_wrap(1), 0);
        chk("dn_tc1", get_tc(1), 1);
        cycle();
        chk("dn_w1_b", get_wrap(1), 1);
        cycle();
        chk("dn_q1_c", get_q(1), 0);
        chk("dn_w1_c", get_wrap(1), 1);

        // LOAD clip and set-beats-clear on ovf
        drv(1, 0, JK, 0, 0, 0, 0); cycle();
        drv(0, 1, LD, 0, 0, 12, 0); cycle();
        chk("ld_q0", get_q(0), 9);
        drv(0, 1, UP, 0, 0, 0, 1); cycle();
        chk("prio_ovf0", get_ovf(0), 1);
        drv(0, 0, UP, 0, 0, 0, 1); cycle();
        chk("oclr_ovf0", get_ovf(0), 0);

        // Enable low holds
        drv(0, 1, LD, 0, 0, 4, 0); cycle();
        drv(0, 0, UP, 0, 0, 0, 0);
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("en_q0", get_q(0), 4);
            chk("en_tc0", get_tc(0), 0);
            chk("en_w0", get_wrap(0), 0);
        end

        // Default 8-bit wrap
        drv(0, 1, LD, 0, 0, 255, 0); cycle();
        drv(0, 1, UP, 0, 0, 0, 0);
        #1;
        chk("def_tc2", get_tc(2), 1);
        cycle();
        chk("def_q2", get_q(2), 0);
        chk("def_w2", get_wrap(2), 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drv(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                8'($urandom), ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
